axil_reg_slave: RTL and testbench

AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

---
 rtl/axil_reg_slave.sv | 133 +++++++++++++
 tb/tb_axil_reg_slave.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing four 32-bit read/write registers, with the live values driven to fabric.
// The write and read channels are independent; AW and W each have their own one-entry buffer.
module axil_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o
);

    localparam int         DW          = C_S_AXI_DATA_WIDTH;
    localparam int         SW          = C_S_AXI_DATA_WIDTH / 8;
    localparam int         AW          = C_S_AXI_ADDR_WIDTH;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DW-1:0] regs [4];

    logic          aw_full, w_full;
    logic [1:0]    aw_idx;
    logic          aw_oor;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;

    logic aw_hs, w_hs, ar_hs, commit;
    logic aw_full_nxt, w_full_nxt, bvalid_nxt, rvalid_nxt;
    logic aw_oor_in, ar_oor_in;

    // Any address bit at or above bit 4 set selects the unmapped region.
    assign aw_oor_in = |S_AXI_AWADDR[AW-1:4];
    assign ar_oor_in = |S_AXI_ARADDR[AW-1:4];

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit = aw_full & w_full;

    assign aw_full_nxt = ~commit & (aw_full | aw_hs);
    assign w_full_nxt  = ~commit & (w_full | w_hs);
    assign bvalid_nxt  = commit | (S_AXI_BVALID & ~S_AXI_BREADY);
    assign rvalid_nxt  = ar_hs | (S_AXI_RVALID & ~S_AXI_RREADY);

    // NOTE: the register file is reset like every other flop because fabric reads it live;
    // a plain storage RAM would normally be left without reset.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_idx        <= '0;
            aw_oor        <= 1'b0;
            w_data        <= '0;
            w_strb        <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, which
            // is also what lets a read on the commit edge return the old register contents.
            aw_full       <= aw_full_nxt;
            w_full        <= w_full_nxt;
            S_AXI_AWREADY <= ~aw_full_nxt & ~bvalid_nxt;
            S_AXI_WREADY  <= ~w_full_nxt & ~bvalid_nxt;
            S_AXI_BVALID  <= bvalid_nxt;
            if (aw_hs) begin
                aw_idx <= S_AXI_AWADDR[3:2];
                aw_oor <= aw_oor_in;
            end
            if (w_hs) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (commit) begin
                S_AXI_BRESP <= aw_oor ? RESP_SLVERR : RESP_OKAY;
                if (!aw_oor) begin
                    for (int k = 0; k < SW; k++) begin
                        if (w_strb[k]) regs[aw_idx][8*k +: 8] <= w_data[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            S_AXI_ARREADY <= ~rvalid_nxt;
            S_AXI_RVALID  <= rvalid_nxt;
            if (ar_hs) begin
                S_AXI_RDATA <= ar_oor_in ? '0 : regs[S_AXI_ARADDR[3:2]];
                S_AXI_RRESP <= ar_oor_in ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign reg0_o = regs[0];
    assign reg1_o = regs[1];
    assign reg2_o = regs[2];
    assign reg3_o = regs[3];

    // Protection bits and byte-lane address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: a transaction-level register model with a per-cycle compare,
// plus literal expectations taken from the documented scenarios.
module tb_axil_reg_slave;

    logic        clk = 1'b0;
    logic        S_AXI_ARESETN;
    logic [4:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [4:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;

    axil_reg_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(S_AXI_ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: register array, pending address/data, queues of owed responses.
    typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
    logic [31:0] m_reg [4];
    bit          m_aw, m_w, m_live;
    logic [4:0]  m_aw_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  bq[$];
    rexp_t       rq[$];

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_aw = 0; m_w = 0; m_live = 0;
        bq.delete(); rq.delete();
    endfunction

    function automatic rexp_t model_read(input logic [4:0] addr);
        rexp_t r;
        r.data = addr[4] ? 32'h0 : m_reg[addr[3:2]];
        r.resp = addr[4] ? 2'b10 : 2'b00;
        return r;
    endfunction

    function automatic void model_commit();
        if (m_aw_addr[4]) begin
            bq.push_back(2'b10);
        end else begin
            for (int k = 0; k < 4; k++)
                if (m_wstrb[k]) m_reg[m_aw_addr[3:2]][8*k +: 8] = m_wdata[8*k +: 8];
            bq.push_back(2'b00);
        end
    endfunction

    // Model update on every rising edge from the handshakes that edge completes.
    initial forever begin
        @(posedge clk);
        if (!S_AXI_ARESETN) begin
            model_clear();
        end else begin
            if (S_AXI_BVALID && S_AXI_BREADY && bq.size() > 0) bq.delete(0);
            if (S_AXI_RVALID && S_AXI_RREADY && rq.size() > 0) rq.delete(0);
            if (S_AXI_ARVALID && S_AXI_ARREADY) rq.push_back(model_read(S_AXI_ARADDR));
            if (m_aw && m_w) begin
                model_commit();
                m_aw = 0; m_w = 0;
            end
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin m_aw = 1; m_aw_addr = S_AXI_AWADDR; end
            if (S_AXI_WVALID && S_AXI_WREADY) begin m_w = 1; m_wdata = S_AXI_WDATA; m_wstrb = S_AXI_WSTRB; end
            m_live = 1;
        end
    end

    // Per-cycle compare of every output against the model, on the falling edge.
    initial forever begin
        @(negedge clk);
        check("reg0_o", reg0_o, m_reg[0]);
        check("reg1_o", reg1_o, m_reg[1]);
        check("reg2_o", reg2_o, m_reg[2]);
        check("reg3_o", reg3_o, m_reg[3]);
        check("awready", 32'(S_AXI_AWREADY), 32'(m_live && !m_aw && bq.size() == 0));
        check("wready",  32'(S_AXI_WREADY),  32'(m_live && !m_w && bq.size() == 0));
        check("arready", 32'(S_AXI_ARREADY), 32'(m_live && rq.size() == 0));
        check("bvalid",  32'(S_AXI_BVALID),  32'(bq.size() != 0));
        check("rvalid",  32'(S_AXI_RVALID),  32'(rq.size() != 0));
        if (S_AXI_BVALID && bq.size() != 0) check("bresp", 32'(S_AXI_BRESP), 32'(bq[0]));
        if (S_AXI_RVALID && rq.size() != 0) begin
            check("rdata", S_AXI_RDATA, rq[0].data);
            check("rresp", 32'(S_AXI_RRESP), 32'(rq[0].resp));
        end
    end

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, input int w_delay, input int b_delay,
                            output logic [1:0] resp);
        int cyc = 0;
        bit aw_done = 0, w_done = 0, b_done = 0;
        resp = 2'b11;
        while (!b_done && cyc < 60) begin
            @(negedge clk);
            S_AXI_AWADDR  = addr;
            S_AXI_WDATA   = data;
            S_AXI_WSTRB   = strb;
            S_AXI_AWVALID = !aw_done && cyc >= aw_delay;
            S_AXI_WVALID  = !w_done && cyc >= w_delay;
            S_AXI_BREADY  = cyc >= b_delay;
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
            if (S_AXI_BVALID && S_AXI_BREADY) begin resp = S_AXI_BRESP; b_done = 1; end
            cyc++;
        end
        check("write_timeout", 32'(b_done), 32'd1);
        @(negedge clk);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    endtask

    task automatic do_read(input logic [4:0] addr, input int ar_delay,
                           output logic [31:0] data, output logic [1:0] resp);
        int cyc = 0;
        bit ar_done = 0, r_done = 0;
        data = 32'hxxxx_xxxx; resp = 2'b11;
        while (!r_done && cyc < 60) begin
            @(negedge clk);
            S_AXI_ARADDR  = addr;
            S_AXI_ARVALID = !ar_done && cyc >= ar_delay;
            S_AXI_RREADY  = 1'b1;
            if (S_AXI_ARVALID && S_AXI_ARREADY) ar_done = 1;
            if (S_AXI_RVALID && S_AXI_RREADY) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; r_done = 1; end
            cyc++;
        end
        check("read_timeout", 32'(r_done), 32'd1);
        @(negedge clk);
        S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    endtask

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd;
        int          n;
        S_AXI_ARESETN = 1'b1;
        model_clear();
        #1 S_AXI_ARESETN = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        #2 S_AXI_ARESETN = 1'b1;

        // Four plain writes then four reads.
        for (int i = 0; i < 4; i++) begin
            do_write(5'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, br);
            check("wr_okay", 32'(br), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(5'(i * 4), 0, rd, rr);
            check("rd_data", rd, 32'(i + 1));
            check("rd_okay", 32'(rr), 32'd0);
        end

        // Byte strobes, including the all-zero strobe.
        do_write(5'h04, 32'h1111_1111, 4'hF, 0, 0, 0, br);
        do_write(5'h04, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, br);
        check("strb_reg1", reg1_o, 32'h11BB_11DD);
        do_read(5'h04, 0, rd, rr);
        check("strb_read", rd, 32'h11BB_11DD);
        do_write(5'h00, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, br);
        check("strb0_resp", 32'(br), 32'd0);
        check("strb0_reg0", reg0_o, 32'h1);

        // W three cycles ahead of AW, BREADY held off well after BVALID.
        do_write(5'h08, 32'h0000_CAFE, 4'hF, 3, 0, 10, br);
        check("late_aw_resp", 32'(br), 32'd0);
        check("late_aw_reg2", reg2_o, 32'h0000_CAFE);

        // Out-of-range write and read.
        do_write(5'h14, 32'h0000_DEAD, 4'hF, 0, 0, 0, br);
        check("oor_bresp", 32'(br), 32'd2);
        do_read(5'h14, 0, rd, rr);
        check("oor_rdata", rd, 32'd0);
        check("oor_rresp", 32'(rr), 32'd2);
        check("oor_reg0", reg0_o, 32'h1);
        check("oor_reg1", reg1_o, 32'h11BB_11DD);
        check("oor_reg2", reg2_o, 32'h0000_CAFE);
        check("oor_reg3", reg3_o, 32'h4);

        // Read sampled on the commit edge of a write to the same register.
        fork
            begin logic [1:0] b; do_write(5'h0C, 32'h55, 4'hF, 0, 0, 0, b); end
            do_read(5'h0C, 1, rd, rr);
        join
        check("same_edge_old", rd, 32'h4);
        do_read(5'h0C, 0, rd, rr);
        check("same_edge_new", rd, 32'h55);

        // Reset between AW and W handshakes abandons the write.
        @(negedge clk);
        S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 10) begin @(negedge clk); n++; end
        check("aw_wait", 32'(S_AXI_AWREADY), 32'd1);
        @(negedge clk);
        S_AXI_AWVALID = 1'b0;
        #2 S_AXI_ARESETN = 1'b0;
        model_clear();
        #1;
        check("mid_rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("mid_rst_wready",  32'(S_AXI_WREADY),  32'd0);
        check("mid_rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("mid_rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check("mid_rst_reg3",    reg3_o,             32'd0);
        repeat (2) @(negedge clk);
        #2 S_AXI_ARESETN = 1'b1;
        @(negedge clk);
        S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        n = 0;
        while (!S_AXI_WREADY && n < 10) begin @(negedge clk); n++; end
        check("w_wait", 32'(S_AXI_WREADY), 32'd1);
        @(negedge clk);
        S_AXI_WVALID = 1'b0;
        repeat (5) @(negedge clk);
        check("w_alone_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("w_alone_reg0", reg0_o, 32'd0);

        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
